// File: rtl/ula_sched_if.sv
// Requester-side handshake bundle for ula_sched: request (valid/ready + op/operands)
// and the response valid/ready pair; rsp_data is shared and stays a top-level port.
interface ula_sched_if;
  logic       valid;
  logic       ready;
  logic [3:0] op;
  logic [3:0] opnd1;
  logic [3:0] opnd2;
  logic       rsp_valid;
  logic       rsp_ready;

  modport master (output valid, op, opnd1, opnd2, rsp_ready,
                  input  ready, rsp_valid);
  modport slave  (input  valid, op, opnd1, opnd2, rsp_ready,
                  output ready, rsp_valid);
endinterface

// File: rtl/ula_sched.sv
// Round-robin scheduler sharing one combinational 4-bit ALU between requesters A and B.
// Optional ULA_SCHED_DIVZ_EN: adds rsp_err and forces a zero result on DIV by zero.
`ifdef ULA_SCHED_DIVZ_EN
`ifndef ULA_DIV
`define ULA_DIV 4'd3
`endif
`endif

module ula_sched #(
  parameter bit RR_START = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  ula_sched_if.slave       a,
  ula_sched_if.slave       b,
  output logic [7:0]       rsp_data,
  output logic             busy,
  output logic [3:0]       ula_operando1,
  output logic [3:0]       ula_operando2,
  output logic [3:0]       ula_opcode,
  input  logic [7:0]       ula_result
`ifdef ULA_SCHED_DIVZ_EN
  ,
  output logic             rsp_err
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   ptr;      // 0 favours A, 1 favours B
  logic   owner;    // 0 = A, 1 = B
  logic   grant_a;
  logic   grant_b;
  logic   a_rsp_q;
  logic   b_rsp_q;

  // Grant is combinational so ready coincides with the accepting cycle.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && state == IDLE) begin
      if (a.valid && (!b.valid || !ptr))
        grant_a = 1'b1;
      else if (b.valid)
        grant_b = 1'b1;
    end
  end

  assign a.ready     = grant_a;
  assign b.ready     = grant_b;
  assign a.rsp_valid = a_rsp_q;
  assign b.rsp_valid = b_rsp_q;
  assign busy        = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= RR_START;
      owner         <= 1'b0;
      ula_opcode    <= 4'd0;
      ula_operando1 <= 4'd0;
      ula_operando2 <= 4'd0;
      rsp_data      <= 8'd0;
      a_rsp_q       <= 1'b0;
      b_rsp_q       <= 1'b0;
`ifdef ULA_SCHED_DIVZ_EN
      rsp_err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            owner         <= grant_b;
            ula_opcode    <= grant_b ? b.op    : a.op;
            ula_operando1 <= grant_b ? b.opnd1 : a.opnd1;
            ula_operando2 <= grant_b ? b.opnd2 : a.opnd2;
            state         <= EXEC;
          end
        end
        EXEC: begin
`ifdef ULA_SCHED_DIVZ_EN
          if (ula_opcode == 4'(`ULA_DIV) && ula_operando2 == 4'd0) begin
            rsp_data <= 8'h00;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= ula_result;
            rsp_err  <= 1'b0;
          end
`else
          rsp_data <= ula_result;
`endif
          a_rsp_q <= ~owner;
          b_rsp_q <= owner;
          state   <= RESP;
        end
        RESP: begin
          // Pointer moves only on completion, towards the non-owner.
          if (owner ? b.rsp_ready : a.rsp_ready) begin
            a_rsp_q <= 1'b0;
            b_rsp_q <= 1'b0;
            ptr     <= ~owner;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sched.sv
// Directed, table-driven bench for ula_sched with a behavioural ALU stand-in
// (ADD=0, SUB=1, MULT=2, DIV=3; DIV by zero yields 8'hFF from this ALU).
module tb_ula_sched;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rsp_data;
  logic       busy;
  logic [3:0] ula_operando1, ula_operando2, ula_opcode;
  logic [7:0] ula_result;
`ifdef ULA_SCHED_DIVZ_EN
  logic       rsp_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  ula_sched_if ia();
  ula_sched_if ib();

  ula_sched #(.RR_START(1'b0)) dut (
    .clock         (clock),
    .reset         (reset),
    .a             (ia),
    .b             (ib),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .ula_operando1 (ula_operando1),
    .ula_operando2 (ula_operando2),
    .ula_opcode    (ula_opcode),
    .ula_result    (ula_result)
`ifdef ULA_SCHED_DIVZ_EN
    ,
    .rsp_err       (rsp_err)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural ALU
  always_comb begin
    case (ula_opcode)
      OP_ADD:  ula_result = 8'(ula_operando1) + 8'(ula_operando2);
      OP_SUB:  ula_result = 8'(ula_operando1) - 8'(ula_operando2);
      OP_MULT: ula_result = 8'(ula_operando1) * 8'(ula_operando2);
      OP_DIV:  ula_result = (ula_operando2 == 4'd0) ? 8'hFF
                            : 8'(ula_operando1) / 8'(ula_operando2);
      default: ula_result = 8'h00;
    endcase
  end

  typedef struct {
    logic       a_valid;
    logic [3:0] a_op, a_1, a_2;
    logic       b_valid;
    logic [3:0] b_op, b_1, b_2;
    logic       exp_b;      // expected winner: 0 = A, 1 = B
    logic [7:0] exp_data;
    logic       exp_err;
    int         hold;       // extra cycles with rsp_ready low
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  function automatic vec_t mk(input logic av, input logic [3:0] aop, input logic [3:0] a1,
                              input logic [3:0] a2, input logic bv, input logic [3:0] bop,
                              input logic [3:0] b1, input logic [3:0] b2, input logic eb,
                              input logic [7:0] ed, input logic ee, input int h);
    vec_t v;
    v.a_valid = av; v.a_op = aop; v.a_1 = a1; v.a_2 = a2;
    v.b_valid = bv; v.b_op = bop; v.b_1 = b1; v.b_2 = b2;
    v.exp_b = eb; v.exp_data = ed; v.exp_err = ee; v.hold = h;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [3:0] eop, e1, e2;
    eop = v.exp_b ? v.b_op : v.a_op;
    e1  = v.exp_b ? v.b_1  : v.a_1;
    e2  = v.exp_b ? v.b_2  : v.a_2;
    ia.valid = v.a_valid; ia.op = v.a_op; ia.opnd1 = v.a_1; ia.opnd2 = v.a_2;
    ib.valid = v.b_valid; ib.op = v.b_op; ib.opnd1 = v.b_1; ib.opnd2 = v.b_2;
    ia.rsp_ready = 1'b0;
    ib.rsp_ready = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'(0));
    chk("grant_a_ready", 32'(ia.ready), 32'(!v.exp_b));
    chk("grant_b_ready", 32'(ib.ready), 32'(v.exp_b));
    step();
    chk("exec_busy", 32'(busy), 32'(1));
    chk("exec_readies", 32'({ia.ready, ib.ready}), 32'(0));
    chk("exec_rsp_valids", 32'({ia.rsp_valid, ib.rsp_valid}), 32'(0));
    chk("ula_opcode", 32'(ula_opcode), 32'(eop));
    chk("ula_operando1", 32'(ula_operando1), 32'(e1));
    chk("ula_operando2", 32'(ula_operando2), 32'(e2));
    step();
    for (int i = 0; i <= v.hold; i++) begin
      chk("resp_a_rsp_valid", 32'(ia.rsp_valid), 32'(!v.exp_b));
      chk("resp_b_rsp_valid", 32'(ib.rsp_valid), 32'(v.exp_b));
      chk("resp_rsp_data", 32'(rsp_data), 32'(v.exp_data));
      chk("resp_busy", 32'(busy), 32'(1));
      chk("resp_readies", 32'({ia.ready, ib.ready}), 32'(0));
      chk("resp_ula_opcode", 32'(ula_opcode), 32'(eop));
`ifdef ULA_SCHED_DIVZ_EN
      chk("resp_rsp_err", 32'(rsp_err), 32'(v.exp_err));
`endif
      if (i < v.hold) step();
    end
    if (v.exp_b) ib.rsp_ready = 1'b1;
    else         ia.rsp_ready = 1'b1;
    step();
    ia.rsp_ready = 1'b0;
    ib.rsp_ready = 1'b0;
    chk("done_busy", 32'(busy), 32'(0));
    chk("done_rsp_valids", 32'({ia.rsp_valid, ib.rsp_valid}), 32'(0));
    ia.valid = 1'b0;
    ib.valid = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_ula_opcode"}, 32'(ula_opcode), 32'(0));
    chk({tag, "_ula_operandos"}, 32'({ula_operando1, ula_operando2}), 32'(0));
    chk({tag, "_rsp_valids"}, 32'({ia.rsp_valid, ib.rsp_valid}), 32'(0));
`ifdef ULA_SCHED_DIVZ_EN
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(0));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dz_data;
    logic       dz_err;
`ifdef ULA_SCHED_DIVZ_EN
    dz_data = 8'h00; dz_err = 1'b1;
`else
    dz_data = 8'hFF; dz_err = 1'b0;
`endif
    // Pointer after each entry is noted; RR_START = 0 favours A.
    vecs[0]  = mk(1, OP_ADD, 4'd7, 4'd9,   0, OP_ADD, 4'd0, 4'd0,  0, 8'h10, 0, 0);   // ->B
    vecs[1]  = mk(1, OP_SUB, 4'd3, 4'd1,   1, OP_ADD, 4'd4, 4'd4,  1, 8'h08, 0, 0);   // ->A
    vecs[2]  = mk(1, OP_MULT, 4'd15, 4'd15, 1, OP_SUB, 4'd2, 4'd5, 0, 8'hE1, 0, 10);  // ->B
    vecs[3]  = mk(1, OP_MULT, 4'd15, 4'd15, 1, OP_SUB, 4'd2, 4'd5, 1, 8'hFD, 0, 0);   // ->A
    vecs[4]  = mk(1, OP_MULT, 4'd15, 4'd15, 1, OP_SUB, 4'd2, 4'd5, 0, 8'hE1, 0, 0);   // ->B
    vecs[5]  = mk(1, OP_MULT, 4'd15, 4'd15, 1, OP_SUB, 4'd2, 4'd5, 1, 8'hFD, 0, 0);   // ->A
    vecs[6]  = mk(0, OP_ADD, 4'd0, 4'd0,   1, OP_MULT, 4'd3, 4'd4, 1, 8'h0C, 0, 0);   // ->A
    vecs[7]  = mk(1, OP_ADD, 4'd15, 4'd15, 1, OP_ADD, 4'd1, 4'd1,  0, 8'h1E, 0, 0);   // ->B
    vecs[8]  = mk(1, OP_SUB, 4'd0, 4'd1,   0, OP_ADD, 4'd0, 4'd0,  0, 8'hFF, 0, 2);   // ->B
    vecs[9]  = mk(1, OP_DIV, 4'd9, 4'd0,   0, OP_ADD, 4'd0, 4'd0,  0, dz_data, dz_err, 0);
    vecs[10] = mk(1, OP_DIV, 4'd9, 4'd2,   0, OP_ADD, 4'd0, 4'd0,  0, 8'h04, 0, 0);   // ->B
    vecs[11] = mk(1, OP_DIV, 4'd7, 4'd7,   1, OP_MULT, 4'd0, 4'd7, 1, 8'h00, 0, 0);   // ->A
    vecs[12] = mk(1, OP_ADD, 4'd0, 4'd0,   0, OP_ADD, 4'd0, 4'd0,  0, 8'h00, 0, 0);   // ->B

    reset = 1'b1;
    ia.valid = 1'b0; ia.op = '0; ia.opnd1 = '0; ia.opnd2 = '0; ia.rsp_ready = 1'b0;
    ib.valid = 1'b0; ib.op = '0; ib.opnd1 = '0; ib.opnd2 = '0; ib.rsp_ready = 1'b0;
    step();
    step();
    chk_cleared("reset");
    chk("reset_readies", 32'({ia.ready, ib.ready}), 32'(0));
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Reset while B's response is pending (pointer currently favours B).
    ia.valid = 1'b1; ia.op = OP_ADD; ia.opnd1 = 4'd1; ia.opnd2 = 4'd2;
    ib.valid = 1'b1; ib.op = OP_ADD; ib.opnd1 = 4'd3; ib.opnd2 = 4'd3;
    #1;
    chk("mid_b_ready", 32'({ia.ready, ib.ready}), 32'(2'b01));
    step();
    step();
    chk("mid_b_rsp_valid", 32'(ib.rsp_valid), 32'(1));
    chk("mid_rsp_data", 32'(rsp_data), 32'(8'h06));
    reset = 1'b1;
    #1;
    chk("mid_reset_readies", 32'({ia.ready, ib.ready}), 32'(0));
    step();
    reset = 1'b0;
    #1;
    chk_cleared("after_reset");
    chk("after_reset_grant", 32'({ia.ready, ib.ready}), 32'(2'b10));
    run_vec(mk(1, OP_ADD, 4'd1, 4'd2, 1, OP_ADD, 4'd3, 4'd3, 0, 8'h03, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
